// File: rtl/ir_key_sched.sv
// ir_key_sched: turns IR receiver codes and two front-panel buttons into key events
// queued in a 4-entry FIFO. Define IR_RELEASE_EV_EN to also queue IR release events.
module ir_key_sched #(
    parameter int unsigned REPEAT_START  = 8,
    parameter int unsigned REPEAT_DIV    = 2,
    parameter int unsigned BTN_DEBOUNCE  = 270000,
    parameter logic [15:0] BTN_CODE_BASE = 16'hFF00
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic [15:0] ir_code,
    input  logic [7:0]  ir_code_cnt,
    input  logic [1:0]  btn_n,
    output logic [15:0] ev_code,
    output logic [1:0]  ev_type,
    output logic        ev_valid,
    input  logic        ev_ack,
    output logic        ev_ovf,
    input  logic        ovf_clr
);
    localparam int unsigned     DB_W      = (BTN_DEBOUNCE < 2) ? 1 : $clog2(BTN_DEBOUNCE);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(BTN_DEBOUNCE - 1);
    localparam logic [7:0]      RPT_START = 8'(REPEAT_START);
    localparam logic [3:0]      RPT_DIV   = 4'(REPEAT_DIV);

    typedef enum logic [1:0] {IR_IDLE = 2'd0, IR_HELD = 2'd1, IR_RPT = 2'd2} ir_state_t;

    logic [1:0]      r_btn_s1, r_btn_s2, r_btn_db;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      w_btn_fire;

    logic [15:0] r_code_q;
    logic [7:0]  r_cnt_q;
    ir_state_t   r_state, w_state_nx;
    logic [3:0]  r_div, w_div_nx;
    logic        w_cnt_chg, w_new_press, w_set_press, w_set_rpt;

    logic        r_pend_press, r_pend_rpt;
    logic [15:0] r_press_code, r_rpt_code;
    logic [1:0]  r_pend_btn;
`ifdef IR_RELEASE_EV_EN
    logic        r_pend_rel, w_set_rel, w_clr_rel;
    logic [15:0] r_rel_code;
`endif
    logic        w_wr_req, w_clr_press, w_clr_rpt;
    logic [1:0]  w_clr_btn;
    logic [17:0] w_wr_data;

    logic [17:0] r_mem [4];
    logic [1:0]  r_wptr, r_rptr;
    logic [2:0]  r_count;
    logic        r_ovf, w_full, w_push, w_pop;

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            r_btn_s1 <= '1;
            r_btn_s2 <= '1;
            r_btn_db <= '1;
            for (int unsigned n = 0; n < 2; n++) r_db_cnt[n] <= '0;
        end else begin
            r_btn_s1 <= btn_n;
            r_btn_s2 <= r_btn_s1;
            for (int unsigned n = 0; n < 2; n++) begin
                if (r_btn_s2[n] == r_btn_db[n]) begin
                    r_db_cnt[n] <= '0;
                end else if (r_db_cnt[n] == DB_LAST) begin
                    r_db_cnt[n] <= '0;
                    r_btn_db[n] <= ~r_btn_db[n];
                end else begin
                    r_db_cnt[n] <= r_db_cnt[n] + 1'b1;
                end
            end
        end
    end

    // A press fires on the same edge the debounced state falls.
    always_comb begin
        w_btn_fire = '0;
        for (int unsigned n = 0; n < 2; n++)
            w_btn_fire[n] = r_btn_db[n] && !r_btn_s2[n] && (r_db_cnt[n] == DB_LAST);
    end

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            r_code_q <= '0;
            r_cnt_q  <= '0;
            r_state  <= IR_IDLE;
            r_div    <= '0;
        end else begin
            r_code_q <= ir_code;
            r_cnt_q  <= ir_code_cnt;
            r_state  <= w_state_nx;
            r_div    <= w_div_nx;
        end
    end

    assign w_cnt_chg   = (ir_code_cnt != r_cnt_q);
    assign w_new_press = (ir_code_cnt == 8'd1) &&
                         (((r_state == IR_IDLE) && (r_cnt_q != 8'd1)) ||
                          ((r_code_q != '0) && (ir_code != r_code_q)));

    always_comb begin
        w_state_nx  = r_state;
        w_div_nx    = r_div;
        w_set_press = 1'b0;
        w_set_rpt   = 1'b0;
`ifdef IR_RELEASE_EV_EN
        w_set_rel   = 1'b0;
`endif
        if (ir_code == '0) begin
            w_state_nx = IR_IDLE;
`ifdef IR_RELEASE_EV_EN
            w_set_rel  = (r_code_q != '0) && (r_state != IR_IDLE);
`endif
        end else if (w_new_press) begin
            w_set_press = 1'b1;
            w_state_nx  = IR_HELD;
        end else begin
            case (r_state)
                IR_HELD: if (w_cnt_chg && (ir_code_cnt >= RPT_START)) begin
                    w_set_rpt  = 1'b1;
                    w_div_nx   = '0;
                    w_state_nx = IR_RPT;
                end
                IR_RPT: if (w_cnt_chg) begin
                    if (r_div + 4'd1 == RPT_DIV) begin
                        w_div_nx  = '0;
                        w_set_rpt = 1'b1;
                    end else begin
                        w_div_nx = r_div + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fixed priority; the selected flag is cleared whether the FIFO accepts it or not.
    always_comb begin
        w_wr_req    = 1'b1;
        w_wr_data   = '0;
        w_clr_press = 1'b0;
        w_clr_rpt   = 1'b0;
        w_clr_btn   = '0;
`ifdef IR_RELEASE_EV_EN
        w_clr_rel   = 1'b0;
`endif
        if (r_pend_press) begin
            w_wr_data   = {2'b00, r_press_code};
            w_clr_press = 1'b1;
`ifdef IR_RELEASE_EV_EN
        end else if (r_pend_rel) begin
            w_wr_data = {2'b10, r_rel_code};
            w_clr_rel = 1'b1;
`endif
        end else if (r_pend_rpt) begin
            w_wr_data = {2'b01, r_rpt_code};
            w_clr_rpt = 1'b1;
        end else if (r_pend_btn[0]) begin
            w_wr_data    = {2'b00, BTN_CODE_BASE};
            w_clr_btn[0] = 1'b1;
        end else if (r_pend_btn[1]) begin
            w_wr_data    = {2'b00, BTN_CODE_BASE + 16'd1};
            w_clr_btn[1] = 1'b1;
        end else begin
            w_wr_req = 1'b0;
        end
    end

    // A new event raised on the edge that consumes the held one replaces it.
    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            r_pend_press <= 1'b0;
            r_pend_rpt   <= 1'b0;
            r_press_code <= '0;
            r_rpt_code   <= '0;
            r_pend_btn   <= '0;
`ifdef IR_RELEASE_EV_EN
            r_pend_rel   <= 1'b0;
            r_rel_code   <= '0;
`endif
        end else begin
            if (w_clr_press) r_pend_press <= 1'b0;
            if (w_set_press) begin
                r_pend_press <= 1'b1;
                r_press_code <= ir_code;
            end
            if (w_clr_rpt) r_pend_rpt <= 1'b0;
            if (w_set_rpt) begin
                r_pend_rpt <= 1'b1;
                r_rpt_code <= ir_code;
            end
`ifdef IR_RELEASE_EV_EN
            if (w_clr_rel) r_pend_rel <= 1'b0;
            if (w_set_rel) begin
                r_pend_rel <= 1'b1;
                r_rel_code <= r_code_q;
            end
`endif
            for (int unsigned n = 0; n < 2; n++) begin
                if (w_clr_btn[n])  r_pend_btn[n] <= 1'b0;
                if (w_btn_fire[n]) r_pend_btn[n] <= 1'b1;
            end
        end
    end

    assign w_full = (r_count == 3'd4);
    assign w_pop  = ev_ack && (r_count != 3'd0);
    assign w_push = w_wr_req && (!w_full || w_pop);

    always_ff @(posedge clk27) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            if (ovf_clr)
                r_ovf <= 1'b0;
            else if (w_wr_req && !w_push)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk27) begin
        if (w_push) r_mem[r_wptr] <= w_wr_data;
    end

    assign ev_valid           = (r_count != 3'd0);
    assign {ev_type, ev_code} = ev_valid ? r_mem[r_rptr] : '0;
    assign ev_ovf             = r_ovf;
endmodule

// File: tb/tb_ir_key_sched.sv
// Self-checking bench for ir_key_sched: scenario tasks plus randomized IR holds
// checked against an arithmetic event model.
module tb_ir_key_sched;
    localparam int unsigned DB = 20;
    localparam int unsigned RS = 8;
    localparam int unsigned RD = 2;

    logic        clk27 = 1'b0;
    logic        reset_n;
    logic [15:0] ir_code;
    logic [7:0]  ir_code_cnt;
    logic [1:0]  btn_n;
    logic [15:0] ev_code;
    logic [1:0]  ev_type;
    logic        ev_valid;
    logic        ev_ack;
    logic        ev_ovf;
    logic        ovf_clr;

    int          errors = 0;
    int          checks = 0;
    logic [17:0] exp_q [$];

    ir_key_sched #(
        .REPEAT_START (RS),
        .REPEAT_DIV   (RD),
        .BTN_DEBOUNCE (DB),
        .BTN_CODE_BASE(16'hFF00)
    ) dut (
        .clk27      (clk27),
        .reset_n    (reset_n),
        .ir_code    (ir_code),
        .ir_code_cnt(ir_code_cnt),
        .btn_n      (btn_n),
        .ev_code    (ev_code),
        .ev_type    (ev_type),
        .ev_valid   (ev_valid),
        .ev_ack     (ev_ack),
        .ev_ovf     (ev_ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk27 = ~clk27;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk27);
            #1;
        end
    endtask

    task automatic pop_one(output logic [17:0] ev, output bit ok);
        ok = 1'b0;
        ev = '0;
        for (int i = 0; i < 300; i++) begin
            if (ev_valid) begin
                ev     = {ev_type, ev_code};
                ok     = 1'b1;
                ev_ack = 1'b1;
                tick(1);
                ev_ack = 1'b0;
                break;
            end
            tick(1);
        end
    endtask

    task automatic ir_press(input logic [15:0] code);
        ir_code     = code;
        ir_code_cnt = 8'd1;
        tick(2);
    endtask

    task automatic ir_release();
        ir_code     = '0;
        ir_code_cnt = '0;
        tick(2);
    endtask

    function automatic void model_release(input logic [15:0] code);
`ifdef IR_RELEASE_EV_EN
        exp_q.push_back({2'b10, code});
`else
        if (code == 16'h0) exp_q.push_back('0);
`endif
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; ir_code = '0; ir_code_cnt = '0; btn_n = 2'b11;
        ev_ack = 1'b0; ovf_clr = 1'b0;
        tick(3);
        checks++; if (ev_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", ev_valid);
        if (ev_valid !== 1'b0) errors++;
        checks++; if (ev_code !== 16'h0) begin errors++; $display("FAIL reset_code: got %h expected 0000", ev_code); end
        checks++; if (ev_type !== 2'b00) begin errors++; $display("FAIL reset_type: got %b expected 00", ev_type); end
        checks++; if (ev_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ev_ovf); end
        reset_n = 1'b1;
        tick(3);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got %b expected 0", ev_valid); end
    endtask

    task automatic test_single_press();
        logic [17:0] ev;
        bit          ok;
        exp_q.delete();
        exp_q.push_back({2'b00, 16'h3E12});
`ifdef IR_RELEASE_EV_EN
        exp_q.push_back({2'b10, 16'h3E12});
`endif
        ir_code = 16'h3E12; ir_code_cnt = 8'd1;
        tick(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL press_latency_early: got %b expected 0", ev_valid); end
        tick(1);
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL press_latency: got %b expected 1", ev_valid); end
        tick(8);
        ir_release();
        tick(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            pop_one(ev, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL single_press_timeout: got none expected %h", exp_q[i]); end
            else if (ev !== exp_q[i]) begin errors++; $display("FAIL single_press_ev: got %h expected %h", ev, exp_q[i]); end
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_press_empty: got %b expected 0", ev_valid); end
    endtask

    task automatic test_hold_repeat();
        logic [17:0] ev;
        bit          ok;
        logic [15:0] code;
        int unsigned n;
        int unsigned n_exp;
        for (int it = 0; it < 6; it++) begin
            code = 16'($urandom_range(1, 65535));
            n    = (it == 0) ? 13 : $urandom_range(1, 30);
            exp_q.delete();
            exp_q.push_back({2'b00, code});
            for (int unsigned c = 2; c <= n; c++)
                if (c >= RS && (c - RS) % RD == 0) exp_q.push_back({2'b01, code});
`ifdef IR_RELEASE_EV_EN
            exp_q.push_back({2'b10, code});
`endif
            n_exp = exp_q.size();
            if (it == 0) begin
                checks++;
                if (n_exp !== 4 + ((exp_q[n_exp-1][17:16] == 2'b10) ? 1 : 0)) begin
                    errors++; $display("FAIL hold_model_count: got %0d expected 4", n_exp);
                end
            end
            fork
                begin
                    ir_code = code;
                    for (int unsigned c = 1; c <= n; c++) begin
                        ir_code_cnt = 8'(c);
                        tick(3);
                    end
                    ir_code = '0; ir_code_cnt = '0;
                    tick(3);
                end
                begin
                    for (int i = 0; i < n_exp; i++) begin
                        tick($urandom_range(0, 2));
                        pop_one(ev, ok);
                        checks++;
                        if (!ok) begin errors++; $display("FAIL hold_timeout: it=%0d got none expected %h", it, exp_q[i]); end
                        else if (ev !== exp_q[i]) begin errors++; $display("FAIL hold_ev: it=%0d idx=%0d got %h expected %h", it, i, ev, exp_q[i]); end
                    end
                end
            join
            tick(5);
            checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL hold_extra: it=%0d got %b expected 0", it, ev_valid); end
            checks++; if (ev_ovf !== 1'b0) begin errors++; $display("FAIL hold_ovf: it=%0d got %b expected 0", it, ev_ovf); end
        end
    endtask

    task automatic test_button();
        logic [17:0] ev;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            btn_n[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
        end
        btn_n[1] = 1'b0;
        tick(26);
        for (int i = 0; i < 4; i++) begin
            btn_n[1] = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick(1);
        end
        btn_n[1] = 1'b1;
        tick(DB + 10);
        pop_one(ev, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL btn1_timeout: got none expected 0ff01"); end
        else if (ev !== {2'b00, 16'hFF01}) begin errors++; $display("FAIL btn1_ev: got %h expected 0ff01", ev); end
        tick(3);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL btn1_single: got %b expected 0", ev_valid); end
        btn_n[1] = 1'b0;
        tick(10);
        btn_n[1] = 1'b1;
        tick(DB + 20);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL btn1_short: got %b expected 0", ev_valid); end
    endtask

    task automatic test_same_cycle();
        logic [17:0] ev;
        bit          ok;
        btn_n[0] = 1'b0;
        tick(DB + 1);
        ir_code = 16'h1234; ir_code_cnt = 8'd1;
        tick(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL same_early: got %b expected 0", ev_valid); end
        tick(1);
        checks++; if ({ev_valid, ev_type, ev_code} !== {1'b1, 2'b00, 16'h1234}) begin
            errors++; $display("FAIL same_first: got %b %h expected 1 01234", ev_valid, {ev_type, ev_code});
        end
        ev_ack = 1'b1;
        tick(1);
        ev_ack = 1'b0;
        checks++; if ({ev_valid, ev_type, ev_code} !== {1'b1, 2'b00, 16'hFF00}) begin
            errors++; $display("FAIL same_second: got %b %h expected 1 0ff00", ev_valid, {ev_type, ev_code});
        end
        ev_ack = 1'b1;
        tick(1);
        ev_ack = 1'b0;
        btn_n[0] = 1'b1;
        ir_release();
        tick(DB + 10);
`ifdef IR_RELEASE_EV_EN
        pop_one(ev, ok);
        checks++;
        if (!ok || ev !== {2'b10, 16'h1234}) begin errors++; $display("FAIL same_release: got %h expected 21234", ev); end
`endif
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL same_empty: got %b expected 0", ev_valid); end
    endtask

    task automatic test_overflow();
        logic [17:0] ev;
        bit          ok;
        logic [17:0] gen_q [$];
        exp_q.delete();
        for (int k = 1; k <= 5; k++) begin
            ir_press(16'hA000 + 16'(k));
            gen_q.push_back({2'b00, 16'hA000 + 16'(k)});
`ifdef IR_RELEASE_EV_EN
            gen_q.push_back({2'b10, 16'hA000 + 16'(k)});
`endif
            ir_release();
        end
        tick(3);
        for (int i = 0; i < 4; i++) exp_q.push_back(gen_q[i]);
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", ev_valid); end
        checks++; if (ev_ovf !== (gen_q.size() > 4)) begin errors++; $display("FAIL ovf_set: got %b expected 1", ev_ovf); end
        checks++; if ({ev_type, ev_code} !== exp_q[0]) begin errors++; $display("FAIL ovf_head: got %h expected %h", {ev_type, ev_code}, exp_q[0]); end
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        checks++; if (ev_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b expected 0", ev_ovf); end
        ir_code = 16'hB007; ir_code_cnt = 8'd1;
        tick(1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        checks++; if (ev_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr_wins: got %b expected 0", ev_ovf); end
        ir_release();
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        ir_code = 16'hB008; ir_code_cnt = 8'd1;
        tick(1);
        ev_ack = 1'b1; tick(1); ev_ack = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back({2'b00, 16'hB008});
        checks++; if (ev_ovf !== 1'b0) begin errors++; $display("FAIL full_ack_write_ovf: got %b expected 0", ev_ovf); end
        for (int i = 0; i < 4; i++) begin
            pop_one(ev, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL ovf_drain_timeout: got none expected %h", exp_q[i]); end
            else if (ev !== exp_q[i]) begin errors++; $display("FAIL ovf_drain: idx=%0d got %h expected %h", i, ev, exp_q[i]); end
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b expected 0", ev_valid); end
        ir_release();
        tick(2);
`ifdef IR_RELEASE_EV_EN
        pop_one(ev, ok);
        checks++;
        if (!ok || ev !== {2'b10, 16'hB008}) begin errors++; $display("FAIL ovf_release: got %h expected 2b008", ev); end
`endif
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_final_empty: got %b expected 0", ev_valid); end
    endtask

    task automatic test_midreset();
        logic [17:0] ev;
        bit          ok;
        ir_press(16'hC001); ir_release();
        ir_press(16'hC002);
`ifndef IR_RELEASE_EV_EN
        ir_release();
        ir_press(16'hC003);
`endif
        tick(3);
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre: got %b expected 1", ev_valid); end
        reset_n = 1'b0; ir_code = '0; ir_code_cnt = '0;
        tick(1);
        reset_n = 1'b1;
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL midreset_flush: got %b expected 0", ev_valid); end
        tick(4);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL midreset_pending: got %b expected 0", ev_valid); end
        exp_q.delete();
        exp_q.push_back({2'b00, 16'hC00D});
        model_release(16'hC00D);
        ir_press(16'hC00D);
        ir_release();
        tick(2);
        for (int i = 0; i < exp_q.size(); i++) begin
            pop_one(ev, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL midreset_timeout: got none expected %h", exp_q[i]); end
            else if (ev !== exp_q[i]) begin errors++; $display("FAIL midreset_ev: got %h expected %h", ev, exp_q[i]); end
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL midreset_empty: got %b expected 0", ev_valid); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_repeat();
        test_button();
        test_same_cycle();
        test_overflow();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
